// File: rtl/stream_pkg.sv
// Shared types and width helpers for stream_arbiter.
// Optional feature macro: STREAM_ARBITER_FIXED_PRIO_EN.
package stream_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // A word counter must be able to hold 0..packet.
  function automatic int cnt_w(input int packet);
    return (packet < 1) ? 1 : $clog2(packet + 1);
  endfunction

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_arbiter_if.sv
// Upstream requester bundle plus downstream tagged stream of stream_arbiter.
// slave = arbiter view, master = requester/sink environment view.
interface stream_arbiter_if
  import stream_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic [N-1:0]         iValid_AM;
  logic [N-1:0]         oReady_AM;
  logic [N*WIDTH-1:0]   iData_AM;
  logic                 oValid_BM;
  logic                 iReady_BM;
  logic [WIDTH-1:0]     oData_BM;
  logic [id_w(N)-1:0]   oId_BM;

  modport slave (
    input  iValid_AM, iData_AM, iReady_BM,
    output oReady_AM, oValid_BM, oData_BM, oId_BM
  );

  modport master (
    output iValid_AM, iData_AM, iReady_BM,
    input  oReady_AM, oValid_BM, oData_BM, oId_BM
  );
endinterface

// File: rtl/stream_arbiter_pick.sv
// Combinational requester pick: first valid index at or after base, wrapping.
// With STREAM_ARBITER_FIXED_PRIO_EN the base is forced to 0 (lowest index wins).
module stream_arbiter_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);

  logic [IW-1:0] base;
  logic [N-1:0]  rot;
  logic [IW-1:0] off;

`ifdef STREAM_ARBITER_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign base       = '0;
`else
  assign base = ptr;
`endif

  // Rotate so that bit 0 is the base requester, priority-encode, then undo the rotation.
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = valid[(i + int'(base)) % N];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
  end

  assign grant = IW'((int'(off) + int'(base)) % N);
  assign any   = |valid;

endmodule

// File: rtl/stream_arbiter.sv
// N-to-1 packet arbiter: holds a grant for PACKET words, registered output tagged with source id.
// Round-robin by default; STREAM_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority.
module stream_arbiter
  import stream_pkg::*;
#(
  parameter int N      = 4,
  parameter int WIDTH  = 8,
  parameter int PACKET = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  stream_arbiter_if.slave   bus,
  output logic              oBusy
);

  localparam int IW = id_w(N);
  localparam int CW = cnt_w(PACKET);

  state_t           state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [CW-1:0]    cnt_q;
  logic             vld_q;
  logic [WIDTH-1:0] dat_q;
  logic [IW-1:0]    id_q;
  logic [N-1:0]     rdy;
  logic             space;
  logic             xfer;
  logic             last;

  stream_arbiter_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .valid (bus.iValid_AM),
    .ptr   (ptr_q),
    .grant (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rdy     = '0;
    xfer    = 1'b0;
    last    = 1'b0;
    space   = !vld_q || bus.iReady_BM;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          grant_d = pick_idx;
        end
      end
      ST_GRANT: begin
        rdy[grant_q] = space;
        xfer         = space && bus.iValid_AM[grant_q];
        last         = xfer && (cnt_q == CW'(PACKET - 1));
        if (last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (xfer) begin
        cnt_q <= last ? '0 : cnt_q + CW'(1);
        vld_q <= 1'b1;
        dat_q <= bus.iData_AM[int'(grant_q)*WIDTH +: WIDTH];
        id_q  <= grant_q;
      end else if (bus.iReady_BM) begin
        vld_q <= 1'b0;
      end
    end
  end

`ifdef STREAM_ARBITER_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  // Next packet starts searching just after the requester that finished.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ptr_q <= '0;
    end else if (last) begin
      ptr_q <= IW'((int'(grant_q) + 1) % N);
    end
  end
`endif

  assign bus.oReady_AM = rdy;
  assign bus.oValid_BM = vld_q;
  assign bus.oData_BM  = dat_q;
  assign bus.oId_BM    = id_q;
  assign oBusy         = (state_q == ST_GRANT) || vld_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter: dut0 N=4 PACKET=4, dut1 N=4 PACKET=1.
// Requester k sends words {k, seq}; expectations are pushed as stimulus is issued.
module tb_stream_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_arbiter_if #(.N(4), .WIDTH(8)) b0 ();
  stream_arbiter_if #(.N(4), .WIDTH(8)) b1 ();
  logic busy0, busy1;

  stream_arbiter #(.N(4), .WIDTH(8), .PACKET(4)) dut0 (
    .iCLK (clk), .iRST (rst), .bus (b0), .oBusy (busy0)
  );
  stream_arbiter #(.N(4), .WIDTH(8), .PACKET(1)) dut1 (
    .iCLK (clk), .iRST (rst), .bus (b1), .oBusy (busy1)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] dat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   budget [2][4] = '{default: 0};
  int   seqn   [2][4] = '{default: 0};
  logic rdy_bm [2]    = '{1'b1, 1'b1};
  int   checks   = 0;
  int   failures = 0;

  always_comb begin
    b0.iValid_AM = '0;
    b0.iData_AM  = '0;
    b1.iValid_AM = '0;
    b1.iData_AM  = '0;
    for (int k = 0; k < 4; k++) begin
      b0.iValid_AM[k]       = budget[0][k] > 0;
      b0.iData_AM[k*8 +: 8] = {2'(k), 6'(seqn[0][k])};
      b1.iValid_AM[k]       = budget[1][k] > 0;
      b1.iData_AM[k*8 +: 8] = {2'(k), 6'(seqn[1][k])};
    end
    b0.iReady_BM = rdy_bm[0];
    b1.iReady_BM = rdy_bm[1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pkt(input int d, input int id, input int first, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.id  = 2'(id);
      e.dat = {2'(id), 6'(first + i)};
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic mon(input int d, input logic [1:0] id, input logic [7:0] dat);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : q1.size();
    chk(d == 0 ? "sb_pending_dut0" : "sb_pending_dut1", 32'(sz > 0), 1);
    if (sz > 0) begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk(d == 0 ? "sb_id_dut0" : "sb_id_dut1", 32'(id), 32'(e.id));
      chk(d == 0 ? "sb_data_dut0" : "sb_data_dut1", 32'(dat), 32'(e.dat));
    end
  endtask

  task automatic wait_idle(input int d, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (d == 0 && !busy0 && q0.size() == 0) break;
      if (d == 1 && !busy1 && q1.size() == 0) break;
      tick();
    end
    if (d == 0) begin
      chk("drain_busy_dut0", 32'(busy0), 0);
      chk("drain_queue_dut0", 32'(q0.size()), 0);
    end else begin
      chk("drain_busy_dut1", 32'(busy1), 0);
      chk("drain_queue_dut1", 32'(q1.size()), 0);
    end
  endtask

  // Sink side: every accepted output word is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (b0.oValid_BM && b0.iReady_BM) mon(0, b0.oId_BM, b0.oData_BM);
        if (b1.oValid_BM && b1.iReady_BM) mon(1, b1.oId_BM, b1.oData_BM);
      end
    end
  end

  // Requester side: a word leaves its source on each valid && ready handshake.
  initial begin
    logic x [2][4];
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        x[0][k] = !rst && b0.iValid_AM[k] && b0.oReady_AM[k];
        x[1][k] = !rst && b1.iValid_AM[k] && b1.oReady_AM[k];
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) begin
          if (x[d][k]) begin
            budget[d][k] = budget[d][k] - 1;
            seqn[d][k]   = seqn[d][k] + 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] pat1;
    logic [8:0]  pat6;
    pat1 = 11'b01111011110;
    pat6 = 9'b010101010;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(b0.oValid_BM), 0);
    chk("rst_ready", 32'(b0.oReady_AM), 0);
    chk("rst_data", 32'(b0.oData_BM), 0);
    chk("rst_id", 32'(b0.oId_BM), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_busy_dut1", 32'(busy1), 0);
    rst = 1'b0;

    // All four requesters; requester 0 has two packets worth of words.
`ifdef STREAM_ARBITER_FIXED_PRIO_EN
    push_pkt(0, 0, 0, 8);
    push_pkt(0, 1, 0, 4);
    push_pkt(0, 2, 0, 4);
    push_pkt(0, 3, 0, 4);
`else
    push_pkt(0, 0, 0, 4);
    push_pkt(0, 1, 0, 4);
    push_pkt(0, 2, 0, 4);
    push_pkt(0, 3, 0, 4);
    push_pkt(0, 0, 4, 4);
`endif
    budget[0][0] = 8;
    budget[0][1] = 4;
    budget[0][2] = 4;
    budget[0][3] = 4;
    wait_idle(0, 200);

    // Requester 2 alone: latency, back-to-back words, one idle cycle between packets.
    push_pkt(0, 2, 4, 8);
    budget[0][2] = 8;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("t1_valid_cycle", 32'(b0.oValid_BM), 32'(pat1[i]));
      if (i == 0) chk("t1_ready_after_idle", 32'(b0.oReady_AM), 32'h4);
    end
    wait_idle(0, 100);

    // Requester 3 stalls mid-packet; requester 0 must not be served meanwhile.
    push_pkt(0, 3, 4, 4);
    push_pkt(0, 0, 8, 4);
    budget[0][3] = 2;
    repeat (3) tick();
    budget[0][0] = 4;
    repeat (4) begin
      tick();
      chk("t4_req0_blocked", 32'(b0.oReady_AM[0]), 0);
      chk("t4_busy_held", 32'(busy0), 1);
    end
    budget[0][3] = 2;
    wait_idle(0, 100);

    // Downstream back-pressure during requester 1's packet.
    push_pkt(0, 1, 4, 4);
    budget[0][1] = 4;
    repeat (3) tick();
    rdy_bm[0] = 1'b0;
    repeat (3) begin
      tick();
      chk("t3_stall_valid", 32'(b0.oValid_BM), 1);
      chk("t3_stall_data", 32'(b0.oData_BM), 32'h45);
      chk("t3_stall_id", 32'(b0.oId_BM), 1);
      chk("t3_stall_ready", 32'(b0.oReady_AM), 0);
    end
    rdy_bm[0] = 1'b1;
    wait_idle(0, 100);

    // Reset with a partial packet granted to requester 2; pointer restarts at 0.
    push_pkt(0, 2, 12, 2);
    budget[0][2] = 2;
    repeat (5) tick();
    chk("t5_busy_before_rst", 32'(busy0), 1);
    rst = 1'b1;
    tick();
    chk("t5_rst_valid", 32'(b0.oValid_BM), 0);
    chk("t5_rst_ready", 32'(b0.oReady_AM), 0);
    chk("t5_rst_busy", 32'(busy0), 0);
    rst = 1'b0;
    push_pkt(0, 1, 8, 4);
    push_pkt(0, 3, 8, 4);
    budget[0][1] = 4;
    budget[0][3] = 4;
    wait_idle(0, 100);

    // PACKET=1: single-word grants, each preceded by an idle cycle.
`ifdef STREAM_ARBITER_FIXED_PRIO_EN
    push_pkt(1, 0, 0, 2);
    push_pkt(1, 3, 0, 2);
`else
    push_pkt(1, 0, 0, 1);
    push_pkt(1, 3, 0, 1);
    push_pkt(1, 0, 1, 1);
    push_pkt(1, 3, 1, 1);
`endif
    budget[1][0] = 2;
    budget[1][3] = 2;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t6_valid_cycle", 32'(b1.oValid_BM), 32'(pat6[i]));
    end
    wait_idle(1, 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
